// File: rtl/instr_fetch_pkg.sv
// Shared constants, opcode/register encodings and fetch state type for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int unsigned AddrWidth  = 5;
  localparam int unsigned InstrWidth = 8;
  localparam int unsigned ResetPc    = 1;
  localparam int unsigned LastAddr   = 31;

  typedef enum logic [3:0] {
    OpNop = 4'd0,
    OpLd  = 4'd1,
    OpSt  = 4'd2,
    OpAdd = 4'd3,
    OpSub = 4'd4,
    OpAnd = 4'd5,
    OpOr  = 4'd6,
    OpXor = 4'd7,
    OpJmp = 4'd8,
    OpHlt = 4'd9
  } opcode_e;

  typedef enum logic [1:0] {
    RegR0 = 2'd0,
    RegR1 = 2'd1,
    RegR2 = 2'd2,
    RegR3 = 2'd3
  } reg_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  // Instruction word layout: {opcode[3:0], 2'b00, rd[1:0]}.
  function automatic logic [InstrWidth-1:0] asm(opcode_e op, reg_e rd);
    return {op, 2'b00, rd};
  endfunction

  localparam logic [InstrWidth-1:0] NopWord = {OpNop, 2'b00, RegR0};

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control pulses, ROM address/data and the decoder valid/ready handshake.
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned AddrW  = AddrWidth,
  parameter int unsigned InstrW = InstrWidth
);

  logic              run;
  logic              halt_req;
  logic              jump_valid;
  logic [AddrW-1:0]  jump_addr;
  logic [AddrW-1:0]  rom_addr;
  logic [InstrW-1:0] rom_data;
  logic [InstrW-1:0] instr;
  logic [AddrW-1:0]  instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;

  // Fetch unit side.
  modport master (
    input  run,
    input  halt_req,
    input  jump_valid,
    input  jump_addr,
    input  rom_data,
    input  instr_ready,
    output rom_addr,
    output instr,
    output instr_pc,
    output instr_valid,
    output halted
  );

  // Controller / ROM / decoder side.
  modport slave (
    output run,
    output halt_req,
    output jump_valid,
    output jump_addr,
    output rom_data,
    output instr_ready,
    input  rom_addr,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    input  halted
  );

endinterface

// File: rtl/instr_fetch_pc.sv
// Program counter: sequential advance with wrap past the last ROM entry, and jump redirection
// that never lands on the reserved address 0.
module instr_fetch_pc
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned RESET_PC   = ResetPc
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_valid_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  advance_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  localparam logic [ADDR_WIDTH-1:0] PcReset = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PcLast  = {ADDR_WIDTH{1'b1}};

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] jump_target;

  always_comb begin
    pc_next     = (pc_q == PcLast) ? PcReset : pc_q + ADDR_WIDTH'(1);
    jump_target = (jump_addr_i == '0) ? PcReset : jump_addr_i;
    pc_d        = pc_q;
    // A jump overrides any advance in the same cycle.
    if (jump_valid_i) begin
      pc_d = jump_target;
    end else if (advance_i) begin
      pc_d = pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PcReset;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives the ROM address from the pc, registers the ROM word and offers it to the
// decoder over valid/ready, with run/halt control and jump flushes.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = AddrWidth,
  parameter int unsigned INSTR_WIDTH = InstrWidth,
  parameter int unsigned RESET_PC    = ResetPc
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_e state_q, state_d;

  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   capture;
  logic                   resume;

  instr_fetch_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_valid_i (bus.jump_valid),
    .jump_addr_i  (bus.jump_addr),
    .advance_i    (capture),
    .pc_o         (pc)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    capture    = 1'b0;
    // A held instruction drops once the decoder takes it.
    valid_d    = valid_q && !bus.instr_ready;
    resume     = bus.run && !bus.halt_req;

    unique case (state_q)
      StIdle: begin
        if (resume) state_d = StFetch;
      end
      StFetch: begin
        if (bus.halt_req) begin
          state_d = StHalted;
        end else if (!bus.jump_valid && (!valid_q || bus.instr_ready)) begin
          capture = 1'b1;
        end
      end
      StHalted: begin
        if (resume) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      instr_d    = bus.rom_data;
      instr_pc_d = pc;
      valid_d    = 1'b1;
    end
    // Jump flushes whatever is in flight; the word at the old pc is never captured.
    if (bus.jump_valid) valid_d = 1'b0;

    halted_d = (state_q == StHalted) && !valid_q && !resume;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      instr_q    <= INSTR_WIDTH'(NopWord);
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.rom_addr    = pc;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

  a_pc_nonzero: assert property (@(posedge clk) disable iff (!rst_n) pc != '0);

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_q && !bus.instr_ready && !bus.jump_valid)
      |=> (valid_q && $stable(instr_q) && $stable(instr_pc_q)));

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Program-counter and fetch stage sitting directly upstream of the 32-entry instruction ROM.
- Drives the ROM address and captures the combinational ROM word into an instruction register.
- Hands the instruction to the decoder over a valid/ready handshake.
- Supports jumps, halt and resume. ROM address 0 is a reserved record and is never fetched.

Parameters:
- ADDR_WIDTH, 5, ROM address width (32 entries).
- INSTR_WIDTH, `INSTRUCTION_WIDTH, instruction word width taken from OpCodes.v.
- RESET_PC, 1, first address fetched after reset and the wrap target.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- run  in  1  single-cycle pulse; starts fetching from IDLE or HALTED.
- halt_req  in  1  pulse; stops issuing new fetches.
- jump_valid  in  1  redirects the PC this cycle.
- jump_addr  in  ADDR_WIDTH  jump target.
- rom_addr  out  ADDR_WIDTH  ROM address, equal to pc (combinational).
- rom_data  in  INSTR_WIDTH  ROM word at rom_addr, same cycle.
- instr  out  INSTR_WIDTH  registered instruction.
- instr_pc  out  ADDR_WIDTH  address instr was fetched from.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decoder accepts instr.
- halted  out  1  fetch stopped and no instruction outstanding.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE.
  - instr = NOP encoding `ASM(`NOP,`R0)`.
  - instr_pc=0, instr_valid=0, halted=0.
  - Reset mid-operation discards any held instruction immediately.
- States: IDLE, FETCH, HALTED.
- IDLE: no fetch. run=1 -> FETCH on the next edge.
- FETCH, advance condition adv = !instr_valid || instr_ready. When adv=1:
  - instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=next(pc).
  - Throughput is 1 instruction/cycle with 1-cycle latency from rom_addr to instr.
- Stall (instr_valid=1, instr_ready=0): instr, instr_pc and pc all hold. Instr must stay stable until accepted.
- next(pc): pc==31 -> RESET_PC, otherwise pc+1. Address 0 is never produced by wrap.
- jump_valid=1 (any state) has priority over the fetch advance:
  - pc <= (jump_addr==0 ? RESET_PC : jump_addr).
  - instr_valid<=0 on the next edge, so the in-flight instruction is flushed.
  - If instr_ready=1 in the same cycle, the handshake still counts as completed for the consumer.
  - No ROM word is captured in the jump cycle. State is otherwise unchanged; a jump in IDLE only loads pc.
- halt_req=1 in FETCH:
  - No capture that cycle; state -> HALTED.
  - A held valid instr stays valid until consumed.
- HALTED:
  - halted = (state==HALTED && !instr_valid), registered one cycle after the condition.
  - run=1 -> FETCH, resuming at the current pc; halted<=0.
- Simultaneous events:
  - halt_req with jump_valid: pc is redirected, then state goes HALTED.
  - run with halt_req: halt wins.
  - run while in FETCH is ignored.
- pc arithmetic is unsigned ADDR_WIDTH and never exceeds 31.

Decomposition:
- Shared package / include (extend OpCodes.v):
  - ADDR_WIDTH, RESET_PC, last-address constant (31).
  - Fetch state encoding (IDLE=2'd0, FETCH=2'd1, HALTED=2'd2).
  - NOP reset word.
- One natural sub-module: fetch_pc, holding the pc register, next(pc) wrap logic and jump-target remapping. The FSM and instruction register stay in instr_fetch.

Test Plan:
- Reset then run pulse, instr_ready=1, default ROM:
  - instr_pc sequence 1,2,3,... with instr = `ASM(`LD,`R3)`, `ASM(`ST,`R2)`, `ASM(`ADD,`R2)`...
  - instr_valid first high one cycle after entering FETCH; address 0 is never driven during fetch.
- Steady fetch, hold instr_ready=0 for 3 cycles at instr_pc=4:
  - instr stays `ASM(`SUB,`R3)`, rom_addr stays 5.
  - On release, the next instr_pc is 5.
- Run 31 fetches:
  - After instr_pc=31 the next instr_pc is 1; rom_addr never equals 0.
- jump_valid with jump_addr=6 while instr_pc=2 is valid:
  - Next cycle instr_valid=0.
  - Following cycle instr=`ASM(`XOR,`R3)`, instr_pc=6.
  - jump_addr=0 -> fetch resumes at 1.
- halt_req while instr_pc=3 is held with instr_ready=0:
  - instr_valid stays 1 and halted=0.
  - After instr_ready=1, halted=1.
  - Then run -> next instr_pc=4.
- Assert rst_n=0 asynchronously mid-stall:
  - instr_valid=0, halted=0 and instr=NOP immediately, without waiting for a clock edge.
  - After release and run, fetch restarts at 1.
